hazard_forward_unit: RTL and testbench

- Parametrised successor to the pipeline's hazard/forwarding logic.
- Keeps its own shadow pipeline of destination-register tags for the stages after ID (default EX/MEM/WB).
- Produces a forwarding select for each of NUM_SRC ID source operands.
- Detects load-use hazards for a configurable load-result stage, drives PC/IF_ID load enables and NOP insertion, and counts stall cycles.

---
 rtl/hazard_forward_unit.sv | 97 +++++++++
 tb/tb_hazard_forward_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the ID stage.
// Tracks destination tags of post-ID stages in a shadow pipeline and selects the youngest producer.
module hazard_forward_unit #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned PC_REG     = 15,
  parameter int unsigned SELW       = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic                       id_rf_enable,
  input  logic                       id_load,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         id_src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src_reg,
  output logic [NUM_SRC*SELW-1:0]    fwd_sel,
  output logic                       stall,
  output logic                       pc_le,
  output logic                       if_id_le,
  output logic                       nop_insert,
  output logic [15:0]                stall_count,
  output logic [FWD_STAGES-1:0]      stage_valid
);

  logic [FWD_STAGES-1:0]             valid_q, rf_en_q, load_q;
  logic [FWD_STAGES-1:0][REG_AW-1:0] rd_q;
  logic [15:0]                       stall_count_q;

  logic              raw_stall;
  logic [REG_AW-1:0] src;
  logic [SELW-1:0]   sel;
  logic              hit_load;
  logic              enter;

  // Scan stages oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    raw_stall = 1'b0;
    fwd_sel   = '0;
    src       = '0;
    sel       = '0;
    hit_load  = 1'b0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      src      = id_src_reg[s*REG_AW +: REG_AW];
      sel      = '0;
      hit_load = 1'b0;
      for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
        if (valid_q[k] && rf_en_q[k] && (rd_q[k] == src) && id_src_valid[s] &&
            (src != REG_AW'(PC_REG))) begin
          sel      = SELW'(k + 1);
          hit_load = load_q[k] && (k < int'(LOAD_STAGE));
        end
      end
      fwd_sel[s*SELW +: SELW] = sel;
      raw_stall = raw_stall | hit_load;
    end
  end

  always_comb begin
    stall      = raw_stall & id_valid & ~flush;
    pc_le      = ~stall;
    if_id_le   = ~stall;
    nop_insert = stall | flush;
    enter      = id_valid & ~stall & ~flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      rf_en_q       <= '0;
      load_q        <= '0;
      rd_q          <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q[0] <= enter;
      rf_en_q[0] <= enter & id_rf_enable;
      load_q[0]  <= enter & id_load;
      rd_q[0]    <= enter ? id_rd : '0;
      for (int k = 1; k < int'(FWD_STAGES); k++) begin
        valid_q[k] <= valid_q[k-1];
        rf_en_q[k] <= rf_en_q[k-1];
        load_q[k]  <= load_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end
      if (stall && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign stall_count = stall_count_q;
  assign stage_valid = valid_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit with default parameters.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_rf_enable, id_load, flush;
  logic [3:0]  id_rd;
  logic [2:0]  id_src_valid;
  logic [11:0] id_src_reg;
  logic [5:0]  fwd_sel;
  logic        stall, pc_le, if_id_le, nop_insert;
  logic [15:0] stall_count;
  logic [2:0]  stage_valid;

  int compared = 0;
  int mismatched = 0;

  hazard_forward_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rf_enable (id_rf_enable),
    .id_load      (id_load),
    .id_rd        (id_rd),
    .flush        (flush),
    .id_src_valid (id_src_valid),
    .id_src_reg   (id_src_reg),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .pc_le        (pc_le),
    .if_id_le     (if_id_le),
    .nop_insert   (nop_insert),
    .stall_count  (stall_count),
    .stage_valid  (stage_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic rf, input logic ld, input logic [3:0] rd);
    id_valid     = v;
    id_rf_enable = rf;
    id_load      = ld;
    id_rd        = rd;
    id_src_valid = 3'b000;
    id_src_reg   = '0;
    flush        = 1'b0;
  endtask

  // Consumer: valid, no register write, one source operand.
  task automatic consumer(input int s, input logic sv, input logic [3:0] r);
    set_id(1'b1, 1'b0, 1'b0, 4'd0);
    id_src_valid[s]      = sv;
    id_src_reg[s*4 +: 4] = r;
    #2;
  endtask

  task automatic chk_ctl(input string tag, input logic st, input logic nop);
    chk({tag, "_stall"}, {15'd0, stall}, {15'd0, st});
    chk({tag, "_pc_le"}, {15'd0, pc_le}, {15'd0, ~st});
    chk({tag, "_if_id_le"}, {15'd0, if_id_le}, {15'd0, ~st});
    chk({tag, "_nop"}, {15'd0, nop_insert}, {15'd0, nop});
  endtask

  initial begin
    // 1. Reset with random inputs
    reset        = 1'b0;
    id_valid     = 1'($urandom);
    id_rf_enable = 1'($urandom);
    id_load      = 1'($urandom);
    id_rd        = 4'($urandom);
    flush        = 1'b0;
    id_src_valid = 3'($urandom);
    id_src_reg   = 12'($urandom);
    step();
    step();
    chk("rst_fwd_sel", {10'd0, fwd_sel}, 16'd0);
    chk_ctl("rst", 1'b0, 1'b0);
    chk("rst_count", stall_count, 16'd0);
    chk("rst_stage_valid", {13'd0, stage_valid}, 16'd0);
    set_id(1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    step();

    // 2. ALU chain on R1
    set_id(1'b1, 1'b1, 1'b0, 4'd1);
    step();
    consumer(0, 1'b1, 4'd1);
    chk("alu_ex", {10'd0, fwd_sel}, 16'h0001);
    chk_ctl("alu_ex", 1'b0, 1'b0);
    step();
    chk("alu_mem", {10'd0, fwd_sel}, 16'h0002);
    step();
    chk("alu_wb", {10'd0, fwd_sel}, 16'h0003);
    chk("alu_wb_stall", {15'd0, stall}, 16'd0);
    step();
    chk("alu_gone", {10'd0, fwd_sel}, 16'h0000);

    // 3. Load-use on R2 via src1
    set_id(1'b1, 1'b1, 1'b1, 4'd2);
    step();
    consumer(1, 1'b1, 4'd2);
    chk_ctl("ldu", 1'b1, 1'b1);
    chk("ldu_fwd", {10'd0, fwd_sel}, 16'h0004);
    step();
    chk_ctl("ldu_after", 1'b0, 1'b0);
    chk("ldu_after_fwd", {10'd0, fwd_sel}, 16'h0008);
    chk("ldu_count", stall_count, 16'd1);
    chk("ldu_stage_valid", {13'd0, stage_valid}, 16'h0006);
    step();

    // 4. Youngest wins on R3 via src2: alu/alu, load-hidden, then load in EX
    set_id(1'b1, 1'b1, 1'b0, 4'd3);
    step();
    set_id(1'b1, 1'b1, 1'b0, 4'd3);
    step();
    consumer(2, 1'b1, 4'd3);
    chk("yw_alu", {10'd0, fwd_sel}, 16'h0010);
    chk("yw_alu_stall", {15'd0, stall}, 16'd0);
    step();
    set_id(1'b1, 1'b1, 1'b1, 4'd3);
    step();
    set_id(1'b1, 1'b1, 1'b0, 4'd3);
    step();
    consumer(2, 1'b1, 4'd3);
    chk("yw_hidden", {10'd0, fwd_sel}, 16'h0010);
    chk("yw_hidden_stall", {15'd0, stall}, 16'd0);
    step();
    set_id(1'b1, 1'b1, 1'b0, 4'd3);
    step();
    set_id(1'b1, 1'b1, 1'b1, 4'd3);
    step();
    consumer(2, 1'b1, 4'd3);
    chk("yw_load", {10'd0, fwd_sel}, 16'h0010);
    chk_ctl("yw_load", 1'b1, 1'b1);
    step();
    chk("yw_load_after", {10'd0, fwd_sel}, 16'h0020);
    chk("yw_load_after_stall", {15'd0, stall}, 16'd0);
    chk("yw_count", stall_count, 16'd2);
    step();

    // 5. Exclusions: PC register, rf_en=0 producer, unused source
    set_id(1'b1, 1'b1, 1'b1, 4'd15);
    step();
    consumer(0, 1'b1, 4'd15);
    chk("pc_fwd", {10'd0, fwd_sel}, 16'h0000);
    chk("pc_stall", {15'd0, stall}, 16'd0);
    step();
    set_id(1'b1, 1'b0, 1'b0, 4'd4);
    step();
    consumer(0, 1'b1, 4'd4);
    chk("store_fwd", {10'd0, fwd_sel}, 16'h0000);
    chk("store_stall", {15'd0, stall}, 16'd0);
    step();
    set_id(1'b1, 1'b1, 1'b1, 4'd5);
    step();
    consumer(0, 1'b0, 4'd5);
    chk("unused_fwd", {10'd0, fwd_sel}, 16'h0000);
    chk("unused_stall", {15'd0, stall}, 16'd0);
    step();

    // 6. Flush during hazard, then reset mid-stall
    set_id(1'b1, 1'b1, 1'b1, 4'd6);
    step();
    consumer(0, 1'b1, 4'd6);
    flush = 1'b1;
    #1;
    chk_ctl("flush", 1'b0, 1'b1);
    chk("flush_fwd", {10'd0, fwd_sel}, 16'h0001);
    step();
    chk("flush_bubble", {15'd0, stage_valid[0]}, 16'd0);
    chk("flush_count", stall_count, 16'd2);
    set_id(1'b1, 1'b1, 1'b1, 4'd7);
    step();
    consumer(0, 1'b1, 4'd7);
    chk("rst_mid_pre_stall", {15'd0, stall}, 16'd1);
    reset = 1'b0;
    #1;
    chk_ctl("rst_mid", 1'b0, 1'b0);
    chk("rst_mid_fwd", {10'd0, fwd_sel}, 16'h0000);
    chk("rst_mid_count", stall_count, 16'd0);
    chk("rst_mid_stage_valid", {13'd0, stage_valid}, 16'd0);
    step();
    reset = 1'b1;
    set_id(1'b0, 1'b0, 1'b0, 4'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
